// File: rtl/sseg_scan_decoder.sv
// Purpose : rebuild the 4-digit value shown on a multiplexed active-low seven-segment bus.
// Latency : a dwell first registered at edge k updates outputs after edge k+STABLE_CYCLES; frame_strobe one edge later.
// Backpres: none; passive observer of the display nets, every cycle is sampled.
//
// Ports:
//   clk, R                  clock and synchronous active-high reset
//   an[3:0], sseg[6:0], dp  observed display bus, all active-low (sseg = {g,f,e,d,c,b,a})
//   digit0..digit3          decoded value per position (0-9, 4'hF = blank)
//   dp_out[3:0]             captured decimal point per position, active-high
//   digit_valid[3:0]        position captured since reset/timeout
//   frame_strobe            one-cycle pulse after all four positions were captured
//   frame_valid             a complete frame has been seen since reset/timeout
//   err                     one-cycle pulse on an illegal stable anode or segment pattern
module sseg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1048576
) (
    input  logic       clk,
    input  logic       R,
    input  logic [3:0] an,
    input  logic [6:0] sseg,
    input  logic       dp,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dp_out,
    output logic [3:0] digit_valid,
    output logic       frame_strobe,
    output logic       frame_valid,
    output logic       err
);

    localparam logic [7:0]  STABLE_L = 8'(STABLE_CYCLES);
    localparam logic [24:0] TO_MAX   = 25'(TIMEOUT);
    localparam logic [24:0] TO_LAST  = 25'(TIMEOUT - 1);

    // Active-low segment pattern to {legal, value}.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = {1'b1, 4'd0};
            7'h79:   r = {1'b1, 4'd1};
            7'h24:   r = {1'b1, 4'd2};
            7'h30:   r = {1'b1, 4'd3};
            7'h19:   r = {1'b1, 4'd4};
            7'h12:   r = {1'b1, 4'd5};
            7'h02:   r = {1'b1, 4'd6};
            7'h78:   r = {1'b1, 4'd7};
            7'h00:   r = {1'b1, 4'd8};
            7'h10:   r = {1'b1, 4'd9};
            7'h7F:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic [11:0]      samp_q, samp_d;
    logic [7:0]       run_q, run_d;
    logic             done_q, done_d;
    logic [3:0][3:0]  dig_q, dig_d;
    logic [3:0]       dpo_q, dpo_d;
    logic [3:0]       vld_q, vld_d;
    logic [3:0]       seen_q, seen_d;
    logic             fstb_q, fstb_d;
    logic             fval_q, fval_d;
    logic             err_q, err_d;
    logic [24:0]      to_q, to_d;

    logic [11:0] samp_in;
    logic        changed;
    logic        fire;
    logic [3:0]  s_an;
    logic [6:0]  s_seg;
    logic        s_dp;
    logic        idle;
    logic        one_low;
    logic [1:0]  pos;
    logic [4:0]  dec;
    logic        legal_cap;

    assign samp_in = {an, sseg, dp};
    assign changed = (samp_in != samp_q);
    assign s_an    = samp_q[11:8];
    assign s_seg   = samp_q[7:1];
    assign s_dp    = samp_q[0];
    assign idle    = (s_an == 4'hF);
    assign dec     = seg_decode(s_seg);

    // Capture once per dwell, judged on the already-registered sample.
    assign fire      = (run_q == STABLE_L) && !done_q;
    assign legal_cap = fire && one_low && dec[4];

    always_comb begin
        one_low = 1'b1;
        pos     = 2'd0;
        case (s_an)
            4'hE:    pos = 2'd0;
            4'hD:    pos = 2'd1;
            4'hB:    pos = 2'd2;
            4'h7:    pos = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_comb begin
        samp_d = samp_in;
        // run_q == 0 only right after reset; the first sample then counts as 1.
        if (changed || (run_q == 8'd0)) begin
            run_d = 8'd1;
        end else if (run_q == 8'd255) begin
            run_d = 8'd255;
        end else begin
            run_d = run_q + 8'd1;
        end
        done_d = changed ? 1'b0 : (done_q | fire);

        dig_d  = dig_q;
        dpo_d  = dpo_q;
        vld_d  = vld_q;
        seen_d = seen_q;
        fval_d = fval_q;
        fstb_d = 1'b0;
        to_d   = to_q;
        err_d  = fire && !idle && !(one_low && dec[4]);

        // Frame completion clears seen first so a same-cycle capture re-arms its bit.
        if (seen_q == 4'hF) begin
            fstb_d = 1'b1;
            fval_d = 1'b1;
            seen_d = 4'h0;
        end

        if (legal_cap) begin
            dig_d[pos]  = dec[3:0];
            dpo_d[pos]  = ~s_dp;
            vld_d[pos]  = 1'b1;
            seen_d[pos] = 1'b1;
            to_d        = 25'd0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + 25'd1;
            // Values stay; only the "fresh" flags are dropped.
            if (to_q == TO_LAST) begin
                vld_d  = 4'h0;
                seen_d = 4'h0;
                fval_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            samp_q <= 12'h000;
            run_q  <= 8'd0;
            done_q <= 1'b0;
            dig_q  <= '0;
            dpo_q  <= 4'h0;
            vld_q  <= 4'h0;
            seen_q <= 4'h0;
            fstb_q <= 1'b0;
            fval_q <= 1'b0;
            err_q  <= 1'b0;
            to_q   <= 25'd0;
        end else begin
            samp_q <= samp_d;
            run_q  <= run_d;
            done_q <= done_d;
            dig_q  <= dig_d;
            dpo_q  <= dpo_d;
            vld_q  <= vld_d;
            seen_q <= seen_d;
            fstb_q <= fstb_d;
            fval_q <= fval_d;
            err_q  <= err_d;
            to_q   <= to_d;
        end
    end

    assign digit0       = dig_q[0];
    assign digit1       = dig_q[1];
    assign digit2       = dig_q[2];
    assign digit3       = dig_q[3];
    assign dp_out       = dpo_q;
    assign digit_valid  = vld_q;
    assign frame_strobe = fstb_q;
    assign frame_valid  = fval_q;
    assign err          = err_q;

endmodule
